// File: rtl/regfile_multiport.sv
// Multi-read, single-write register file for the decode stage.
// A clear sequencer sweeps every entry to zero after reset or on request.
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear_req,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic                    busy,
    output logic                    wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_READY = 2'd1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                busy_q, busy_d;
    logic                wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_drop_d = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = '0;
                wr_drop_d = wr_en;
                // A request mid-sweep restarts from entry 0 rather than finishing early.
                if (clear_req) begin
                    clr_cnt_d = '0;
                end else if (&clr_cnt_q) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                mem_we = wr_en && !is_zero_addr(wr_addr);
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Storage carries no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;
        rd_data = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra  = rd_addr[k*ADDR_W +: ADDR_W];
            val = '0;
            if (state_q == ST_READY && !is_zero_addr(ra)) begin
                if (BYPASS != 0 && wr_en && wr_addr == ra) begin
                    val = wr_data;
                end else begin
                    val = mem_q[ra];
                end
            end
            rd_data[k*DATA_W +: DATA_W] = val;
        end
    end

    assign busy    = busy_q;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport (4 read ports): vector table for READY-state
// read/write behaviour, hand-written sequences for sweep, drop, restart and async reset.
module tb_regfile_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear_req;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             busy;
    logic             wr_drop;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_multiport #(
        .DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .wr_drop(wr_drop)
    );

    typedef struct {
        logic            we;
        logic [4:0]      wa;
        logic [31:0]     wd;
        logic [3:0][4:0] ra;
        logic [3:0][31:0] ex;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] r0, r1, r2, r3,
                                input logic [31:0] e0, e1, e2, e3);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.ra[0] = r0; v.ra[1] = r1; v.ra[2] = r2; v.ra[3] = r3;
        v.ex[0] = e0; v.ex[1] = e1; v.ex[2] = e2; v.ex[3] = e3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_rd(input logic [4:0] a0, a1, a2, a3);
        rd_addr = {a3, a2, a1, a0};
    endtask

    function automatic logic [31:0] port(input int k);
        return rd_data[k*DW +: DW];
    endfunction

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_ports(input string name, input logic [31:0] exp);
        for (int k = 0; k < NR; k++) chk($sformatf("%s_p%0d", name, k), port(k), exp);
    endtask

    task automatic wait_idle(input int start, output int n);
        n = start;
        while (busy === 1'b1 && n < 100) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; clear_req = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;

        vecs[0] = mk(1, 5'd8,  32'hDEADBEEF, 8, 0, 5, 8,  32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
        vecs[1] = mk(0, 5'd8,  32'h0,        8, 8, 1, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        vecs[2] = mk(1, 5'd0,  32'h12345678, 0, 0, 8, 0,  0, 0, 32'hDEADBEEF, 0);
        vecs[3] = mk(0, 5'd0,  32'h0,        0, 0, 0, 0,  0, 0, 0, 0);
        vecs[4] = mk(1, 5'd3,  32'hA5A5A5A5, 3, 8, 0, 3,  32'hA5A5A5A5, 32'hDEADBEEF, 0, 32'hA5A5A5A5);
        vecs[5] = mk(1, 5'd3,  32'h00000001, 3, 3, 3, 3,  1, 1, 1, 1);
        vecs[6] = mk(0, 5'd3,  32'h0,        3, 3, 3, 3,  1, 1, 1, 1);
        vecs[7] = mk(1, 5'd31, 32'hFFFFFFFF, 31, 30, 3, 8, 32'hFFFFFFFF, 0, 1, 32'hDEADBEEF);
        vecs[8] = mk(0, 5'd5,  32'h77777777, 5, 31, 8, 0, 0, 32'hFFFFFFFF, 32'hDEADBEEF, 0);

        // Reset and initial sweep
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_drop", {31'b0, wr_drop}, 32'd0);
        set_rd(5'd1, 5'd8, 5'd31, 5'd0);
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (n == 0 || n == 31) chk_all_ports($sformatf("sweep0_c%0d", n), 32'h0);
            cyc();
            n++;
        end
        chk("sweep0_len", n, 32);

        // READY-state vectors
        for (int i = 0; i < 9; i++) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            set_rd(vecs[i].ra[0], vecs[i].ra[1], vecs[i].ra[2], vecs[i].ra[3]);
            #1;
            for (int k = 0; k < NR; k++)
                chk($sformatf("vec%0d_p%0d", i, k), port(k), vecs[i].ex[k]);
            chk($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'd0);
            chk($sformatf("vec%0d_drop", i), {31'b0, wr_drop}, 32'd0);
            cyc();
        end
        wr_en = 1'b0;

        // Load r1..r31, then clear with a concurrent write, and a write mid-sweep
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h1000_0000 + 32'(i) * 32'h0101;
            cyc();
        end
        wr_en = 1'b0;
        set_rd(5'd1, 5'd2, 5'd17, 5'd31);
        #1;
        chk("load_r1",  port(0), 32'h1000_0101);
        chk("load_r2",  port(1), 32'h1000_0202);
        chk("load_r17", port(2), 32'h1000_1111);
        chk("load_r31", port(3), 32'h1000_1F1F);
        clear_req = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55;
        cyc();
        clear_req = 1'b0; wr_en = 1'b0;
        chk("clr_busy", {31'b0, busy}, 32'd1);
        chk_all_ports("clr_rd", 32'h0);
        repeat (5) cyc();
        chk("clr_nodrop", {31'b0, wr_drop}, 32'd0);
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hBAD0BAD0;
        cyc();
        wr_en = 1'b0;
        chk("drop_hi", {31'b0, wr_drop}, 32'd1);
        cyc();
        chk("drop_lo", {31'b0, wr_drop}, 32'd0);
        wait_idle(7, n);
        chk("sweep1_len", n, 32);
        for (int b = 0; b < 32; b += 4) begin
            set_rd(5'(b), 5'(b + 1), 5'(b + 2), 5'(b + 3));
            #1;
            chk_all_ports($sformatf("post_clr_r%0d", b), 32'h0);
        end

        // clear_req during a sweep restarts it from entry 0
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        repeat (9) cyc();
        chk("restart_mid_busy", {31'b0, busy}, 32'd1);
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        wait_idle(0, n);
        chk("restart_len", n, 32);

        // Async reset at sweep cycle 10 clears a pending drop and restarts the sweep
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        repeat (9) cyc();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h3;
        cyc();
        wr_en = 1'b0;
        chk("pre_rst_drop", {31'b0, wr_drop}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_busy", {31'b0, busy}, 32'd1);
        chk("async_drop", {31'b0, wr_drop}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_idle(0, n);
        chk("sweep2_len", n, 32);

        // Normal write/read after recovery
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h4444;
        cyc();
        wr_en = 1'b0;
        set_rd(5'd4, 5'd4, 5'd3, 5'd4);
        #1;
        chk("final_p0", port(0), 32'h4444);
        chk("final_p1", port(1), 32'h4444);
        chk("final_p2", port(2), 32'h0);
        chk("final_p3", port(3), 32'h4444);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
